// File: rtl/mpsoc_uart_wb_pkg.sv
// Shared types and constants for the Wishbone-to-UART register bridge.
// Holds the bridge FSM encoding, recovery counter width and the legal bus widths.
package mpsoc_uart_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_TERM,
        ST_RECOVER
    } bridge_state_t;

    localparam int CNT_W     = 4;
    localparam int DW_NARROW = 8;
    localparam int DW_WIDE   = 32;

endpackage

// File: rtl/mpsoc_wb_uart_lane_dec.sv
// Byte-select decoder: turns a Wishbone select into a byte lane index and a
// flag saying whether the select was a clean one-hot pattern.
module mpsoc_wb_uart_lane_dec
    import mpsoc_uart_wb_pkg::*;
#(
    parameter int DW = 8
)(
    input  logic [DW/8-1:0] i_sel,
    output logic [1:0]      o_lane,
    output logic            o_legal
);

    localparam int SW = DW / 8;

    logic [2:0] w_ones;

    // Scanning from the top down leaves the lowest set bit as the lane, which
    // is also the fallback used when a non-one-hot select is tolerated.
    always_comb begin
        o_lane = 2'd0;
        w_ones = 3'd0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (i_sel[i]) begin
                o_lane = 2'(i);
            end
            w_ones = w_ones + 3'(i_sel[i]);
        end
        o_legal = (DW != DW_WIDE) || (w_ones == 3'd1);
    end

endmodule

// File: rtl/mpsoc_wb_uart_bridge_gen.sv
// Wishbone slave that turns single bus cycles into byte-wide register strobes
// for a UART core, with registered inputs and a fixed post-ack recovery gap.
module mpsoc_wb_uart_bridge_gen
    import mpsoc_uart_wb_pkg::*;
#(
    parameter int DW          = 8,
    parameter int AW          = 3,
    parameter int WAIT_CYCLES = 2,
    parameter int ERR_EN      = 1
)(
    input  logic            clk,
    input  logic            wb_rst_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic [AW-1:0]   reg_adr_o,
    output logic [7:0]      reg_dat_o,
    input  logic [7:0]      reg_dat_i,
    output logic            reg_we_o,
    output logic            reg_re_o
);

    localparam int                 SW     = DW / 8;
    localparam bit                 WIDE   = (DW != DW_NARROW);
    localparam logic [CNT_W-1:0]   RELOAD = CNT_W'(WAIT_CYCLES - 1);

    logic            r_cyc;
    logic            r_stb;
    logic            r_we;
    logic [SW-1:0]   r_sel;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_dat;

    bridge_state_t   r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]      r_lane;
    logic [DW-1:0]   r_wb_dat;
    logic            r_ack;
    logic            r_err;
    logic            r_reg_we;
    logic            r_reg_re;
    logic [AW-1:0]   r_reg_adr;
    logic [7:0]      r_reg_dat;

    logic [1:0]      w_lane;
    logic            w_legal;
    logic            w_err_sel;
    logic [AW-1:0]   w_adr;
    logic [7:0]      w_byte;
    logic [DW-1:0]   w_rd_lane;

    // Bus inputs are registered first so the FSM never sees raw bus timing.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_sel <= '0;
            r_adr <= '0;
            r_dat <= '0;
        end else begin
            r_cyc <= wb_cyc_i;
            r_stb <= wb_stb_i;
            r_we  <= wb_we_i;
            r_sel <= wb_sel_i;
            r_adr <= wb_adr_i;
            r_dat <= wb_dat_i;
        end
    end

    mpsoc_wb_uart_lane_dec #(
        .DW (DW)
    ) u_lane_dec (
        .i_sel   (r_sel),
        .o_lane  (w_lane),
        .o_legal (w_legal)
    );

    // On the wide bus the lane replaces the two low address bits.
    assign w_err_sel = WIDE && (ERR_EN != 0) && !w_legal;
    assign w_adr     = WIDE ? ((r_adr & ~AW'(3)) | AW'(w_lane)) : r_adr;
    assign w_byte    = 8'(r_dat >> {w_lane, 3'b000});
    assign w_rd_lane = DW'({24'd0, reg_dat_i} << {r_lane, 3'b000});

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_lane    <= 2'd0;
            r_wb_dat  <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_reg_we  <= 1'b0;
            r_reg_re  <= 1'b0;
            r_reg_adr <= '0;
            r_reg_dat <= '0;
        end else begin
            r_reg_we <= 1'b0;
            r_reg_re <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_cyc && r_stb) begin
                        if (w_err_sel) begin
                            r_err   <= 1'b1;
                            r_state <= ST_TERM;
                        end else begin
                            r_reg_we  <= r_we;
                            r_reg_re  <= !r_we;
                            r_reg_adr <= w_adr;
                            r_reg_dat <= w_byte;
                            r_lane    <= w_lane;
                            r_state   <= ST_ACCESS;
                        end
                    end
                end
                // A master that drops cyc here loses the ack, but the core
                // has already seen the strobe.
                ST_ACCESS: begin
                    if (r_cyc) begin
                        r_ack    <= 1'b1;
                        r_wb_dat <= w_rd_lane;
                        r_state  <= ST_TERM;
                    end else begin
                        r_cnt   <= RELOAD;
                        r_state <= ST_RECOVER;
                    end
                end
                ST_TERM: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_cnt   <= RELOAD;
                    r_state <= ST_RECOVER;
                end
                ST_RECOVER: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_dat_o  = r_wb_dat;
    assign wb_ack_o  = r_ack;
    assign wb_err_o  = r_err;
    assign reg_adr_o = r_reg_adr;
    assign reg_dat_o = r_reg_dat;
    assign reg_we_o  = r_reg_we;
    assign reg_re_o  = r_reg_re;

endmodule
